// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction-memory port A and IF/ID bundle
interface fetch_stage_if;
  logic       stall;
  logic       flush;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic [7:0] if_pc;
  logic [7:0] if_pc_next;
  logic       if_valid;

  modport master (
    input  stall,
    input  flush,
    input  branch_taken,
    input  branch_target,
    output imem_addr,
    input  imem_data,
    output if_instr,
    output if_imm,
    output if_pc,
    output if_pc_next,
    output if_valid
  );

  modport slave (
    output stall,
    output flush,
    output branch_taken,
    output branch_target,
    input  imem_addr,
    output imem_data,
    input  if_instr,
    input  if_imm,
    input  if_pc,
    input  if_pc_next,
    input  if_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and 1/2-byte instruction assembler feeding IF/ID
module fetch_stage #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [3:0] IMM_OPCODE   = 4'hC
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    fif
);

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] op_hold_q, op_hold_d;
  logic [7:0] op_pc_q, op_pc_d;
  logic [7:0] if_instr_q, if_instr_d;
  logic [7:0] if_imm_q, if_imm_d;
  logic [7:0] if_pc_q, if_pc_d;
  logic [7:0] if_pc_next_q, if_pc_next_d;
  logic       if_valid_q, if_valid_d;
  logic [7:0] pc_inc;

  assign pc_inc = pc_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    op_hold_d    = op_hold_q;
    op_pc_d      = op_pc_q;
    if_instr_d   = if_instr_q;
    if_imm_d     = if_imm_q;
    if_pc_d      = if_pc_q;
    if_pc_next_d = if_pc_next_q;
    if_valid_d   = if_valid_q;

    // Redirect dominates: any half-assembled 2-byte instruction is dropped.
    if (fif.branch_taken) begin
      pc_d       = fif.branch_target;
      state_d    = S_OP;
      if_valid_d = 1'b0;
    end else if (fif.flush) begin
      if_valid_d = 1'b0;
    end else if (!fif.stall) begin
      case (state_q)
        S_OP: begin
          pc_d = pc_inc;
          if (fif.imem_data[7:4] == IMM_OPCODE) begin
            op_hold_d  = fif.imem_data;
            op_pc_d    = pc_q;
            if_valid_d = 1'b0;
            state_d    = S_IMM;
          end else begin
            if_instr_d   = fif.imem_data;
            if_imm_d     = 8'h00;
            if_pc_d      = pc_q;
            if_pc_next_d = pc_inc;
            if_valid_d   = 1'b1;
          end
        end
        S_IMM: begin
          if_instr_d   = op_hold_q;
          if_imm_d     = fif.imem_data;
          if_pc_d      = op_pc_q;
          if_pc_next_d = pc_inc;
          if_valid_d   = 1'b1;
          pc_d         = pc_inc;
          state_d      = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_OP;
      pc_q         <= RESET_VECTOR;
      op_hold_q    <= 8'h00;
      op_pc_q      <= 8'h00;
      if_instr_q   <= 8'h00;
      if_imm_q     <= 8'h00;
      if_pc_q      <= 8'h00;
      if_pc_next_q <= 8'h00;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_hold_q    <= op_hold_d;
      op_pc_q      <= op_pc_d;
      if_instr_q   <= if_instr_d;
      if_imm_q     <= if_imm_d;
      if_pc_q      <= if_pc_d;
      if_pc_next_q <= if_pc_next_d;
      if_valid_q   <= if_valid_d;
    end
  end

  assign fif.imem_addr  = pc_q;
  assign fif.if_instr   = if_instr_q;
  assign fif.if_imm     = if_imm_q;
  assign fif.if_pc      = if_pc_q;
  assign fif.if_pc_next = if_pc_next_q;
  assign fif.if_valid   = if_valid_q;

endmodule
